// File: rtl/riscv_core_mem_arbiter_if.sv
// Core-side and memory-side handshake bundle for the icache/dcache memory arbiter.
interface riscv_core_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned CORE_DATA_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH  = 256
);
  localparam int unsigned STRB_W = 8;

  logic                       ic_read_req;
  logic [ADDR_WIDTH-1:0]      ic_read_addr;
  logic                       ic_read_done;
  logic [AXI_DATA_WIDTH-1:0]  ic_read_data;

  logic                       dc_read_req;
  logic [ADDR_WIDTH-1:0]      dc_read_addr;
  logic                       dc_read_done;
  logic [AXI_DATA_WIDTH-1:0]  dc_read_data;

  logic                       dc_write_valid;
  logic [ADDR_WIDTH-1:0]      dc_write_addr;
  logic [CORE_DATA_WIDTH-1:0] dc_write_data;
  logic [STRB_W-1:0]          dc_write_strobe;
  logic                       dc_write_done;

  logic                       mem_read_req;
  logic [ADDR_WIDTH-1:0]      mem_read_address;
  logic                       mem_read_done;
  logic [AXI_DATA_WIDTH-1:0]  mem_read_data;

  logic                       mem_write_valid;
  logic [ADDR_WIDTH-1:0]      mem_write_address;
  logic [CORE_DATA_WIDTH-1:0] mem_write_data;
  logic [STRB_W-1:0]          mem_write_strobe;
  logic                       mem_write_done;

  logic                       busy;

  // Arbiter side
  modport slave (
    input  ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
    input  dc_write_valid, dc_write_addr, dc_write_data, dc_write_strobe,
    input  mem_read_done, mem_read_data, mem_write_done,
    output ic_read_done, ic_read_data, dc_read_done, dc_read_data, dc_write_done,
    output mem_read_req, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data, mem_write_strobe,
    output busy
  );

  // Caches plus memory model side
  modport master (
    output ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
    output dc_write_valid, dc_write_addr, dc_write_data, dc_write_strobe,
    output mem_read_done, mem_read_data, mem_write_done,
    input  ic_read_done, ic_read_data, dc_read_done, dc_read_data, dc_write_done,
    input  mem_read_req, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data, mem_write_strobe,
    input  busy
  );
endinterface

// File: rtl/riscv_core_mem_arbiter.sv
// Round-robin arbiter serializing icache refill, dcache refill and dcache
// write-through onto a single outstanding memory transaction.
module riscv_core_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned CORE_DATA_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH  = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  riscv_core_mem_arbiter_if.slave   bus
);
  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned LINE_BITS = 6;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << LINE_BITS) - 1);

  localparam logic [1:0] SRC_DWR = 2'd0;
  localparam logic [1:0] SRC_DRD = 2'd1;
  localparam logic [1:0] SRC_IRD = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_DWR = 2'd1,
    GNT_DRD = 2'd2,
    GNT_IRD = 2'd3
  } state_e;

  state_e     state, state_next;
  logic [1:0] last_grant, last_grant_next;

  logic [NUM_REQ-1:0]        req;
  logic                      win_found;
  logic [1:0]                win;
  logic [1:0]                cand;
  logic [AXI_DATA_WIDTH-1:0] rd_line;

  assign req     = {bus.ic_read_req, bus.dc_read_req, bus.dc_write_valid};
  assign rd_line = bus.mem_read_data;

  // Refill data goes to both caches; only the done strobe qualifies it
  assign bus.ic_read_data = rd_line;
  assign bus.dc_read_data = rd_line;

  // Reset leaves DWR as the first candidate of the search
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_grant <= SRC_IRD;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next            = state;
    last_grant_next       = last_grant;
    win_found             = 1'b0;
    win                   = SRC_DWR;
    cand                  = SRC_DWR;
    bus.ic_read_done      = 1'b0;
    bus.dc_read_done      = 1'b0;
    bus.dc_write_done     = 1'b0;
    bus.mem_read_req      = 1'b0;
    bus.mem_read_address  = '0;
    bus.mem_write_valid   = 1'b0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = CORE_DATA_WIDTH'(0);
    bus.mem_write_strobe  = '0;
    bus.busy              = (state != IDLE);

    case (state)
      IDLE: begin
        // Search starts one past the previous winner, wrapping modulo 3
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          cand = 2'((32'(last_grant) + k + 32'd1) % NUM_REQ);
          if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win       = cand;
          end
        end
        if (win_found) begin
          last_grant_next = win;
          case (win)
            SRC_DWR: state_next = GNT_DWR;
            SRC_DRD: state_next = GNT_DRD;
            default: state_next = GNT_IRD;
          endcase
        end
      end

      GNT_DWR: begin
        bus.mem_write_valid   = !bus.mem_write_done;
        bus.mem_write_address = bus.dc_write_addr;
        bus.mem_write_data    = bus.dc_write_data;
        bus.mem_write_strobe  = bus.dc_write_strobe;
        if (bus.mem_write_done) begin
          bus.dc_write_done = 1'b1;
          state_next        = IDLE;
        end
      end

      GNT_DRD: begin
        bus.mem_read_req     = !bus.mem_read_done;
        bus.mem_read_address = bus.dc_read_addr & LINE_MASK;
        if (bus.mem_read_done) begin
          bus.dc_read_done = 1'b1;
          state_next       = IDLE;
        end
      end

      GNT_IRD: begin
        bus.mem_read_req     = !bus.mem_read_done;
        bus.mem_read_address = bus.ic_read_addr & LINE_MASK;
        if (bus.mem_read_done) begin
          bus.ic_read_done = 1'b1;
          state_next       = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Directed bench for riscv_core_mem_arbiter: grant order, handshakes, reset abort.
module tb_riscv_core_mem_arbiter;
  localparam int unsigned AW = 64;
  localparam int unsigned CW = 64;
  localparam int unsigned DW = 256;

  logic i_clk;
  logic i_rst_n;
  int   n_tests;
  int   n_fail;

  riscv_core_mem_arbiter_if #(.ADDR_WIDTH(AW), .CORE_DATA_WIDTH(CW), .AXI_DATA_WIDTH(DW)) bus ();

  riscv_core_mem_arbiter #(.ADDR_WIDTH(AW), .CORE_DATA_WIDTH(CW), .AXI_DATA_WIDTH(DW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam logic [DW-1:0] D1 = {4{64'hA5A5_0001_1111_2222}};
  localparam logic [DW-1:0] D2 = {4{64'h5A5A_0002_3333_4444}};
  localparam logic [DW-1:0] D3 = {4{64'h0F0F_0003_5555_6666}};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_rst_n = 1'b0;
    bus.ic_read_req = 1'b0;     bus.ic_read_addr = '0;
    bus.dc_read_req = 1'b0;     bus.dc_read_addr = '0;
    bus.dc_write_valid = 1'b0;  bus.dc_write_addr = '0;
    bus.dc_write_data = '0;     bus.dc_write_strobe = '0;
    bus.mem_read_done = 1'b0;   bus.mem_read_data = '0;
    bus.mem_write_done = 1'b0;

    // Reset state
    @(negedge i_clk); #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rd_req", bus.mem_read_req, 1'b0);
    chk("rst_wr_valid", bus.mem_write_valid, 1'b0);
    chk("rst_ic_done", bus.ic_read_done, 1'b0);
    @(negedge i_clk); i_rst_n = 1'b1;

    // Single icache refill, line address aligned down to 64 bytes
    @(negedge i_clk);
    bus.ic_read_req = 1'b1; bus.ic_read_addr = 64'h0000_0000_8000_0047; #1;
    chk("t1_idle_no_req", bus.mem_read_req, 1'b0);
    @(negedge i_clk); #1;
    chk("t1_rd_req", bus.mem_read_req, 1'b1);
    chk("t1_rd_addr", bus.mem_read_address, 64'h0000_0000_8000_0040);
    chk("t1_busy", bus.busy, 1'b1);
    chk("t1_no_wr", bus.mem_write_valid, 1'b0);
    bus.mem_read_done = 1'b1; bus.mem_read_data = D1; #1;
    chk("t1_ic_done", bus.ic_read_done, 1'b1);
    chk("t1_ic_data", bus.ic_read_data, D1);
    chk("t1_dc_done", bus.dc_read_done, 1'b0);
    chk("t1_req_drop", bus.mem_read_req, 1'b0);
    @(negedge i_clk);
    bus.mem_read_done = 1'b0; bus.ic_read_req = 1'b0; #1;
    chk("t1_ic_done_end", bus.ic_read_done, 1'b0);
    chk("t1_idle_busy", bus.busy, 1'b0);

    // All three requesters at once: DWR, DRD, IRD in order
    @(negedge i_clk);
    bus.dc_write_valid = 1'b1; bus.dc_write_addr = 64'h0000_0000_0000_1003;
    bus.dc_write_data = 64'hDEAD_BEEF_CAFE_F00D; bus.dc_write_strobe = 8'b0000_1111;
    bus.dc_read_req = 1'b1; bus.dc_read_addr = 64'h1234_5678_9ABC_DEFF;
    bus.ic_read_req = 1'b1; bus.ic_read_addr = 64'h0000_0000_0000_2FFF; #1;
    chk("t2_idle_busy", bus.busy, 1'b0);
    @(negedge i_clk); #1;
    chk("t2_dwr_valid", bus.mem_write_valid, 1'b1);
    chk("t2_dwr_addr", bus.mem_write_address, 64'h0000_0000_0000_1003);
    chk("t2_dwr_data", bus.mem_write_data, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t2_dwr_strobe", bus.mem_write_strobe, 8'b0000_1111);
    chk("t2_dwr_no_rd", bus.mem_read_req, 1'b0);
    // Read done during a write grant must be ignored
    bus.mem_read_done = 1'b1; #1;
    chk("t2_rd_done_ign_w", bus.dc_write_done, 1'b0);
    chk("t2_rd_done_ign_r", bus.dc_read_done, 1'b0);
    chk("t2_rd_done_ign_v", bus.mem_write_valid, 1'b1);
    @(negedge i_clk);
    bus.mem_read_done = 1'b0; #1;
    chk("t2_grant_held", bus.mem_write_valid, 1'b1);
    @(negedge i_clk);
    bus.mem_write_done = 1'b1; #1;
    chk("t2_wr_done", bus.dc_write_done, 1'b1);
    chk("t2_wr_valid_drop", bus.mem_write_valid, 1'b0);
    @(negedge i_clk);
    bus.mem_write_done = 1'b0; bus.dc_write_valid = 1'b0; #1;
    chk("t2_gap1_busy", bus.busy, 1'b0);
    chk("t2_gap1_wr_done", bus.dc_write_done, 1'b0);
    @(negedge i_clk); #1;
    chk("t2_drd_req", bus.mem_read_req, 1'b1);
    chk("t2_drd_addr", bus.mem_read_address, 64'h1234_5678_9ABC_DEC0);
    bus.mem_read_done = 1'b1; bus.mem_read_data = D2; #1;
    chk("t2_drd_done", bus.dc_read_done, 1'b1);
    chk("t2_drd_data", bus.dc_read_data, D2);
    chk("t2_drd_no_ic", bus.ic_read_done, 1'b0);
    @(negedge i_clk);
    bus.mem_read_done = 1'b0; bus.dc_read_req = 1'b0; #1;
    chk("t2_gap2_busy", bus.busy, 1'b0);
    @(negedge i_clk); #1;
    chk("t2_ird_req", bus.mem_read_req, 1'b1);
    chk("t2_ird_addr", bus.mem_read_address, 64'h0000_0000_0000_2FC0);
    bus.mem_read_done = 1'b1; bus.mem_read_data = D3; #1;
    chk("t2_ird_done", bus.ic_read_done, 1'b1);
    chk("t2_ird_data", bus.ic_read_data, D3);
    chk("t2_ird_no_dc", bus.dc_read_done, 1'b0);
    @(negedge i_clk);
    bus.mem_read_done = 1'b0; bus.ic_read_req = 1'b0; #1;
    chk("t2_end_busy", bus.busy, 1'b0);

    // DRD and IRD held: grants alternate starting with DRD
    @(negedge i_clk);
    bus.dc_read_req = 1'b1; bus.dc_read_addr = 64'h0000_0000_0000_1000;
    bus.ic_read_req = 1'b1; bus.ic_read_addr = 64'h0000_0000_0000_2000;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); #1;
      chk("t3_rr_addr", bus.mem_read_address,
          (i % 2 == 0) ? 64'h0000_0000_0000_1000 : 64'h0000_0000_0000_2000);
      @(negedge i_clk);
      @(negedge i_clk);
      bus.mem_read_done = 1'b1; #1;
      chk("t3_rr_dc_done", bus.dc_read_done, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("t3_rr_ic_done", bus.ic_read_done, (i % 2 == 0) ? 1'b0 : 1'b1);
      @(negedge i_clk);
      bus.mem_read_done = 1'b0; #1;
      chk("t3_rr_gap_busy", bus.busy, 1'b0);
    end
    bus.dc_read_req = 1'b0; bus.ic_read_req = 1'b0;

    // Done strobes while idle are ignored
    @(negedge i_clk);
    bus.mem_read_done = 1'b1; bus.mem_write_done = 1'b1; #1;
    chk("t4_idle_ic_done", bus.ic_read_done, 1'b0);
    chk("t4_idle_dc_done", bus.dc_read_done, 1'b0);
    chk("t4_idle_wr_done", bus.dc_write_done, 1'b0);
    @(negedge i_clk);
    bus.mem_read_done = 1'b0; bus.mem_write_done = 1'b0; #1;
    chk("t4_idle_busy", bus.busy, 1'b0);

    // Reset in the middle of a DRD grant, then DWR priority on restart
    @(negedge i_clk);
    bus.dc_read_req = 1'b1; bus.dc_read_addr = 64'h0000_0000_0000_1000;
    @(negedge i_clk); #1;
    chk("t5_drd_req", bus.mem_read_req, 1'b1);
    i_rst_n = 1'b0; #1;
    chk("t5_rst_rd_req", bus.mem_read_req, 1'b0);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_no_done", bus.dc_read_done, 1'b0);
    bus.dc_write_valid = 1'b1; bus.dc_write_addr = 64'h0000_0000_0000_0008;
    bus.dc_write_strobe = 8'b1111_0000;
    @(negedge i_clk);
    i_rst_n = 1'b1; #1;
    chk("t5_rel_busy", bus.busy, 1'b0);
    @(negedge i_clk); #1;
    chk("t5_dwr_first", bus.mem_write_valid, 1'b1);
    chk("t5_dwr_no_rd", bus.mem_read_req, 1'b0);
    bus.mem_write_done = 1'b1; #1;
    chk("t5_wr_done", bus.dc_write_done, 1'b1);
    @(negedge i_clk);
    bus.mem_write_done = 1'b0; bus.dc_write_valid = 1'b0; #1;
    chk("t5_gap_busy", bus.busy, 1'b0);
    @(negedge i_clk); #1;
    chk("t5_drd_regrant", bus.mem_read_req, 1'b1);
    chk("t5_drd_addr", bus.mem_read_address, 64'h0000_0000_0000_1000);
    bus.mem_read_done = 1'b1; #1;
    chk("t5_drd_done", bus.dc_read_done, 1'b1);
    @(negedge i_clk);
    bus.mem_read_done = 1'b0; bus.dc_read_req = 1'b0; #1;
    chk("t5_end_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
